// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with a single outstanding imem request
module fetch_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_VEC = '0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic [1:0]      pc_src_in,
    input  logic [XLEN-1:0] branch_tgt_in,
    input  logic [XLEN-1:0] jump_tgt_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [31:0]     imem_rdata_in,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            valid_out,
    input  logic            id_ready_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;

    assign redirect = !flush_in && (pc_src_in != 2'b11);

    always_comb begin
        target_raw = fetch_pc_q;
        case (pc_src_in)
            2'b00:   target_raw = RESET_VEC;
            2'b01:   target_raw = branch_tgt_in;
            2'b10:   target_raw = jump_tgt_in;
            default: target_raw = fetch_pc_q;
        endcase
        target = target_raw & {{(XLEN-2){1'b1}}, 2'b00};
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (flush_in) begin
            valid_d    = 1'b0;
            fetch_pc_d = RESET_VEC;
            if (state_q == WAIT) begin
                // A response arriving with the flush settles the outstanding request.
                if (imem_rvalid_in) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    drop_d = 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                    if (redirect) fetch_pc_d = target;
                end
                REQ: begin
                    if (redirect) fetch_pc_d = target;
                    if (imem_gnt_in) begin
                        state_d = WAIT;
                        drop_d  = redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_in) begin
                        if (drop_q || redirect) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                            if (redirect) fetch_pc_d = target;
                        end else begin
                            instr_d    = imem_rdata_in;
                            pc_d       = fetch_pc_q;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_q + XLEN'(4);
                            state_d    = HOLD;
                        end
                    end else if (redirect) begin
                        fetch_pc_d = target;
                        drop_d     = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        valid_d    = 1'b0;
                        fetch_pc_d = target;
                        state_d    = REQ;
                    end else if (id_ready_in) begin
                        valid_d = 1'b0;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VEC;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req_out  = (state_q == REQ);
    assign imem_addr_out = fetch_pc_q;
    assign instr_out     = instr_q;
    assign pc_out        = pc_q;
    assign valid_out     = valid_q;

endmodule
